// File: rtl/pad_pkg.sv
// Shared types and constants for the NES/SNES pad reader.
// Defining SNES_MODE_EN selects the 16-bit SNES frame instead of the 8-bit NES frame.
package pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SAMPLE,
    ST_CLKLO,
    ST_DONE
  } pad_state_t;

  // Bit positions in the shifted word; bit 0 is the first bit out of the pad.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int TICK_US = 6;

`ifdef SNES_MODE_EN
  localparam int NBITS = 16;
`else
  localparam int NBITS = 8;
`endif

  // Opposing directions together mean a broken pad or a floating data line.
  function automatic logic frame_ok(input logic [15:0] w);
    return !((w[BTN_UP] & w[BTN_DOWN]) | (w[BTN_LEFT] & w[BTN_RIGHT]));
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick DIV cycles after reset.
module tick_gen #(
  parameter int DIV = 6
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES pad (SNES when SNES_MODE_EN is defined) once per poll period and publishes
// the deserialised word plus validated direction flags, all updated together in the DONE cycle.
module nes_pad_reader
  import pad_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int POLL_HZ = 60
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PadData,
  output logic        PadLatch,
  output logic        PadClk,
  output logic        NU,
  output logic        ND,
  output logic        NL,
  output logic        NR,
  output logic        NReadable,
  output logic [15:0] Buttons
);

  localparam int TICK_DIV   = CLK_HZ / 1_000_000 * TICK_US;
  localparam int POLL_TICKS = 1_000_000 / (TICK_US * POLL_HZ);
  localparam int PW         = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);

  logic          tick;
  logic          start;
  logic [PW-1:0] poll_cnt;
  logic [1:0]    data_sync;
  logic          pad_bit;
  pad_state_t    state;
  pad_state_t    state_nxt;
  logic [3:0]    idx;
  logic          lat_cnt;
  logic [15:0]   shift;

  tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .tick (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_sync <= '0;
    end else begin
      data_sync <= {data_sync[0], PadData};
    end
  end

  // Buttons pull the line low when pressed.
  assign pad_bit = ~data_sync[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= (poll_cnt == PW'(POLL_TICKS - 1)) ? '0 : poll_cnt + 1'b1;
    end
  end

  assign start = tick && (poll_cnt == PW'(POLL_TICKS - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LATCH;
      ST_LATCH:  if (tick && lat_cnt) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (tick) state_nxt = ST_CLKLO;
      ST_CLKLO:  if (tick) state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_SAMPLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pad strobes are decoded from the next state so they leave a flop with no decode glitches.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PadLatch <= 1'b0;
      PadClk   <= 1'b1;
    end else begin
      PadLatch <= (state_nxt == ST_LATCH);
      PadClk   <= (state_nxt != ST_CLKLO);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx     <= '0;
      lat_cnt <= 1'b0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= '0;
            lat_cnt <= 1'b0;
            shift   <= '0;
          end
        end
        ST_LATCH:  if (tick) lat_cnt <= 1'b1;
        ST_SAMPLE: if (tick) shift[idx] <= pad_bit;
        ST_CLKLO:  if (tick && (idx != LAST_IDX)) idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      NU        <= 1'b0;
      ND        <= 1'b0;
      NL        <= 1'b0;
      NR        <= 1'b0;
      NReadable <= 1'b0;
      Buttons   <= '0;
    end else if (state == ST_DONE) begin
      NU        <= frame_ok(shift) & shift[BTN_UP];
      ND        <= frame_ok(shift) & shift[BTN_DOWN];
      NL        <= frame_ok(shift) & shift[BTN_LEFT];
      NR        <= frame_ok(shift) & shift[BTN_RIGHT];
      NReadable <= frame_ok(shift);
      Buttons   <= shift;
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboarded bench for nes_pad_reader with a behavioural shift-register pad model.
module tb_nes_pad_reader;

`ifdef SNES_MODE_EN
  localparam int NB = 16;
  localparam logic [15:0] MASK = 16'hFFFF;
`else
  localparam int NB = 8;
  localparam logic [15:0] MASK = 16'h00FF;
`endif
  localparam int TICK = 6;

  typedef struct {
    logic [15:0] btn;
    logic [3:0]  dirs;
    logic        rd;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PadData;
  logic        PadLatch, PadClk, NU, ND, NL, NR, NReadable;
  logic [15:0] Buttons;

  logic [15:0] pad_word = 16'h0000;
  bit          disc = 1'b0;
  logic [3:0]  pad_idx = 4'd0;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  nes_pad_reader #(
    .CLK_HZ (1_000_000),
    .POLL_HZ(10000)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .PadData  (PadData),
    .PadLatch (PadLatch),
    .PadClk   (PadClk),
    .NU       (NU),
    .ND       (ND),
    .NL       (NL),
    .NR       (NR),
    .NReadable(NReadable),
    .Buttons  (Buttons)
  );

  always #5 CLK = ~CLK;

  // Pad: latch reloads bit 0, each PadClk rise advances one bit; line is low when pressed.
  always @(posedge PadClk or posedge PadLatch) begin
    if (PadLatch) pad_idx <= 4'd0;
    else          pad_idx <= pad_idx + 4'd1;
  end
  assign PadData = disc ? 1'b0 : ~pad_word[pad_idx];

  function automatic exp_t model(input logic [15:0] w, input bit d);
    exp_t e;
    logic [15:0] b;
    b = d ? MASK : (w & MASK);
    e.btn  = b;
    e.rd   = !((b[4] & b[5]) | (b[6] & b[7]));
    e.dirs = e.rd ? b[7:4] : 4'h0;
    return e;
  endfunction

  task automatic wait_latch(output int n, output bit to);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (PadLatch !== 1'b1 && n < 400);
    to = (PadLatch !== 1'b1);
  endtask

  // Counts PadClk low pulses until the line has stayed high well past a tick.
  task automatic run_pulses(output int pulses, output int bad, output bit to);
    int n = 0;
    int lw = 0;
    int hw = 0;
    pulses = 0;
    bad = 0;
    to = 1'b0;
    forever begin
      @(negedge CLK);
      n++;
      if (PadClk === 1'b0) begin
        lw++;
        hw = 0;
      end else begin
        if (lw > 0) begin
          pulses++;
          if (lw != TICK) bad++;
        end
        lw = 0;
        hw++;
      end
      if (pulses > 0 && hw >= TICK + 3) break;
      if (n > 1000) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n, w, p, bad;
    bit to, to2;
    exp_t e;
    repeat (3) @(negedge CLK);
    checks++; if (PadLatch !== 1'b0) begin errors++; $display("FAIL rst_latch got %b want 0", PadLatch); end
    checks++; if (PadClk !== 1'b1) begin errors++; $display("FAIL rst_clk got %b want 1", PadClk); end
    checks++; if ({NU, ND, NL, NR} !== 4'b0) begin errors++; $display("FAIL rst_dirs got %b want 0000", {NU, ND, NL, NR}); end
    checks++; if (NReadable !== 1'b0) begin errors++; $display("FAIL rst_readable got %b want 0", NReadable); end
    checks++; if (Buttons !== 16'h0) begin errors++; $display("FAIL rst_buttons got %h want 0000", Buttons); end
    pad_word = 16'h0000;
    disc = 1'b0;
    sb.push_back(model(pad_word, disc));
    RST_N = 1'b1;
    wait_latch(n, to);
    checks++; if (to || n != 96) begin errors++; $display("FAIL first_latch_delay got %0d want 96", n); end
    w = 0;
    while (PadLatch === 1'b1 && w < 100) begin
      w++;
      @(negedge CLK);
    end
    checks++; if (w != 12) begin errors++; $display("FAIL latch_width got %0d want 12", w); end
    run_pulses(p, bad, to2);
    e = sb.pop_front();
    checks++; if (to2 || p != NB) begin errors++; $display("FAIL first_pulses got %0d want %0d", p, NB); end
    checks++; if (NReadable !== e.rd || Buttons !== e.btn) begin
      errors++; $display("FAIL first_frame got rd=%b btn=%h want rd=%b btn=%h", NReadable, Buttons, e.rd, e.btn);
    end
  endtask

  task automatic test_left_right;
    int n, p, bad;
    bit to, to2;
    exp_t e;
    pad_word = 16'h00C0;
    disc = 1'b0;
    sb.push_back(model(pad_word, disc));
    wait_latch(n, to);
    run_pulses(p, bad, to2);
    e = sb.pop_front();
    checks++; if (to || to2 || p != NB || bad != 0) begin errors++; $display("FAIL lr_pulses got %0d bad=%0d want %0d", p, bad, NB); end
    checks++; if (Buttons !== e.btn) begin errors++; $display("FAIL lr_buttons got %h want %h", Buttons, e.btn); end
    checks++; if ({NR, NL, ND, NU} !== e.dirs) begin errors++; $display("FAIL lr_dirs got %b want %b", {NR, NL, ND, NU}, e.dirs); end
    checks++; if (NReadable !== e.rd) begin errors++; $display("FAIL lr_readable got %b want %b", NReadable, e.rd); end
  endtask

  task automatic test_disconnected;
    int n, p, bad;
    bit to, to2;
    exp_t e;
    disc = 1'b1;
    sb.push_back(model(pad_word, disc));
    wait_latch(n, to);
    run_pulses(p, bad, to2);
    e = sb.pop_front();
    disc = 1'b0;
    checks++; if (to || to2 || p != NB) begin errors++; $display("FAIL disc_pulses got %0d want %0d", p, NB); end
    checks++; if (Buttons !== e.btn) begin errors++; $display("FAIL disc_buttons got %h want %h", Buttons, e.btn); end
    checks++; if (NReadable !== e.rd || {NR, NL, ND, NU} !== e.dirs) begin
      errors++; $display("FAIL disc_valid got rd=%b dirs=%b want rd=%b dirs=%b", NReadable, {NR, NL, ND, NU}, e.rd, e.dirs);
    end
  endtask

  task automatic test_up;
    int n, p, bad;
    bit to, to2;
    exp_t e;
    pad_word = 16'h0010;
    disc = 1'b0;
    sb.push_back(model(pad_word, disc));
    wait_latch(n, to);
    run_pulses(p, bad, to2);
    e = sb.pop_front();
    checks++; if (to || to2 || p != NB) begin errors++; $display("FAIL up_pulses got %0d want %0d", p, NB); end
    checks++; if (bad != 0) begin errors++; $display("FAIL up_pulse_width got %0d bad pulses want 0", bad); end
    checks++; if (Buttons !== e.btn) begin errors++; $display("FAIL up_buttons got %h want %h", Buttons, e.btn); end
    checks++; if ({NR, NL, ND, NU} !== e.dirs) begin errors++; $display("FAIL up_dirs got %b want %b", {NR, NL, ND, NU}, e.dirs); end
    checks++; if (NReadable !== e.rd) begin errors++; $display("FAIL up_readable got %b want %b", NReadable, e.rd); end
  endtask

  task automatic test_reset_mid_frame;
    int n, p, bad;
    int pulses = 0;
    int k = 0;
    logic prev = 1'b1;
    bit to, to2;
    exp_t e;
    pad_word = 16'h0020;
    wait_latch(n, to);
    // Walk into the third SAMPLE phase: two low pulses complete, PadClk high again.
    while (!(pulses == 2 && PadClk === 1'b1) && k < 600) begin
      @(negedge CLK);
      k++;
      if (prev === 1'b0 && PadClk === 1'b1) pulses++;
      prev = PadClk;
    end
    checks++; if (to || k >= 600) begin errors++; $display("FAIL mid_reach_sample got %0d pulses want 2", pulses); end
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (PadClk !== 1'b1 || PadLatch !== 1'b0) begin
      errors++; $display("FAIL mid_pad_pins got clk=%b latch=%b want clk=1 latch=0", PadClk, PadLatch);
    end
    checks++; if ({NU, ND, NL, NR, NReadable} !== 5'b0 || Buttons !== 16'h0) begin
      errors++; $display("FAIL mid_outputs got dirs=%b rd=%b btn=%h want all 0", {NU, ND, NL, NR}, NReadable, Buttons);
    end
    repeat (3) @(negedge CLK);
    pad_word = 16'h0040;
    sb.push_back(model(pad_word, disc));
    RST_N = 1'b1;
    wait_latch(n, to);
    checks++; if (to || NReadable !== 1'b0 || Buttons !== 16'h0) begin
      errors++; $display("FAIL mid_no_partial got rd=%b btn=%h want rd=0 btn=0000", NReadable, Buttons);
    end
    run_pulses(p, bad, to2);
    e = sb.pop_front();
    checks++; if (to2 || p != NB || bad != 0) begin errors++; $display("FAIL mid_next_pulses got %0d bad=%0d want %0d", p, bad, NB); end
    checks++; if (Buttons !== e.btn || {NR, NL, ND, NU} !== e.dirs || NReadable !== e.rd) begin
      errors++; $display("FAIL mid_next_frame got btn=%h dirs=%b rd=%b want btn=%h dirs=%b rd=%b",
                         Buttons, {NR, NL, ND, NU}, NReadable, e.btn, e.dirs, e.rd);
    end
  endtask

  // Right + A: in SNES builds A is bit 8; in NES builds bit 8 is never shifted and reads 0.
  task automatic test_right_a;
    int n, p, bad;
    bit to, to2;
    exp_t e;
    pad_word = 16'h0180;
    disc = 1'b0;
    sb.push_back(model(pad_word, disc));
    wait_latch(n, to);
    run_pulses(p, bad, to2);
    e = sb.pop_front();
    checks++; if (to || to2 || p != NB || bad != 0) begin errors++; $display("FAIL ra_pulses got %0d bad=%0d want %0d", p, bad, NB); end
    checks++; if (Buttons !== e.btn) begin errors++; $display("FAIL ra_buttons got %h want %h", Buttons, e.btn); end
    checks++; if (NR !== e.dirs[3] || NReadable !== e.rd) begin
      errors++; $display("FAIL ra_right got NR=%b rd=%b want NR=%b rd=%b", NR, NReadable, e.dirs[3], e.rd);
    end
  endtask

  initial begin
    test_reset();
    test_left_right();
    test_disconnected();
    test_up();
    test_reset_mid_frame();
    test_right_a();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
